// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports and the memory port of the arbiter.
//   Fetch requester : i_req_in, i_addr_in -> i_ack_out, i_rdata_out
//   Data requester  : d_req_in, d_we_in, d_be_in, d_addr_in, d_wdata_in -> d_ack_out, d_rdata_out
//   Memory port     : mem_en_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out <- mem_rdata_in
// The slave modport is the arbiter's view; the master modport is the view of the
// requesters and memory that surround it.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic        i_req_in;
  logic [31:0] i_addr_in;
  logic        i_ack_out;
  logic [31:0] i_rdata_out;

  logic        d_req_in;
  logic        d_we_in;
  logic [3:0]  d_be_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic        d_ack_out;
  logic [31:0] d_rdata_out;

  logic        mem_en_out;
  logic        mem_we_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [31:0] mem_rdata_in;

  modport slave (
    input  i_req_in, i_addr_in,
    input  d_req_in, d_we_in, d_be_in, d_addr_in, d_wdata_in,
    input  mem_rdata_in,
    output i_ack_out, i_rdata_out,
    output d_ack_out, d_rdata_out,
    output mem_en_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out
  );

  modport master (
    output i_req_in, i_addr_in,
    output d_req_in, d_we_in, d_be_in, d_addr_in, d_wdata_in,
    output mem_rdata_in,
    input  i_ack_out, i_rdata_out,
    input  d_ack_out, d_rdata_out,
    input  mem_en_out, mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and
// a load/store port. One transaction is in flight at a time; ties are broken
// round-robin, fetch winning the first tie after reset.
// Ports:
//   clkin   system clock (rising edge)
//   rst_in  asynchronous active-high reset
//   bus     mem_arbiter_if.slave: fetch port, data port and memory port
// Parameter:
//   MEM_LAT memory read latency in cycles from mem_en_out to valid mem_rdata_in (1..4)
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic          clkin,
  input  logic          rst_in,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // ISSUE is the first latency cycle, so WAIT covers the remaining MEM_LAT-1.
  localparam logic [1:0] WAIT_LOAD = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  state_t      state;
  state_t      state_nxt;
  logic        grant_d;
  logic        last_d;
  logic        pick_d;
  logic        any_req;
  logic [1:0]  wait_cnt;
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        done_i;
  logic        done_d;
  logic        done_load;

  assign any_req = bus.i_req_in | bus.d_req_in;

  // On a tie the side that did not win last time is granted.
  always_comb begin
    pick_d = bus.d_req_in;
    if (bus.i_req_in && bus.d_req_in) begin
      pick_d = ~last_d;
    end
  end

  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT > 1) ? WAIT : DONE;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      grant_d   <= 1'b0;
      last_d    <= 1'b1;
      wait_cnt  <= 2'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'b0000;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      // Grant and request fields are frozen here for the whole transaction.
      if (state == IDLE && any_req) begin
        grant_d   <= pick_d;
        last_d    <= pick_d;
        lat_we    <= pick_d & bus.d_we_in;
        lat_be    <= pick_d ? bus.d_be_in : 4'b0000;
        lat_addr  <= pick_d ? bus.d_addr_in : bus.i_addr_in;
        lat_wdata <= pick_d ? bus.d_wdata_in : 32'd0;
      end
      if (state == ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 2'd0) begin
        wait_cnt <= wait_cnt - 2'd1;
      end
      // DONE is the cycle MEM_LAT after ISSUE, when read data is on mem_rdata_in.
      if (done_i) begin
        i_rdata_q <= bus.mem_rdata_in;
      end
      if (done_load) begin
        d_rdata_q <= bus.mem_rdata_in;
      end
    end
  end

  assign done_i    = (state == DONE) & ~grant_d;
  assign done_d    = (state == DONE) &  grant_d;
  assign done_load = done_d & ~lat_we;

  assign bus.mem_en_out    = (state == ISSUE);
  assign bus.mem_we_out    = lat_we;
  assign bus.mem_be_out    = lat_be;
  assign bus.mem_addr_out  = lat_addr;
  assign bus.mem_wdata_out = lat_wdata;

  assign bus.i_ack_out = done_i;
  assign bus.d_ack_out = done_d;

  // Read data is forwarded straight from memory during the ack cycle and held
  // in the capture register afterwards.
  assign bus.i_rdata_out = done_i    ? bus.mem_rdata_in : i_rdata_q;
  assign bus.d_rdata_out = done_load ? bus.mem_rdata_in : d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 1, memory read latency in cycles from mem_en_out to mem_rdata_in valid; legal range 1..4.
REQ-002 clkin  input  1  system clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 i_req_in  input  1  instruction-fetch request; held with i_addr_in stable until i_ack_out.
REQ-005 i_addr_in  input  32  fetch byte address (the PC).
REQ-006 i_ack_out  output  1  one-cycle fetch completion pulse.
REQ-007 i_rdata_out  output  32  fetched instruction; valid while i_ack_out is high, held afterwards.
REQ-008 d_req_in  input  1  data request; held with all d_* inputs stable until d_ack_out.
REQ-009 d_we_in  input  1  1 = store, 0 = load.
REQ-010 d_be_in  input  4  store byte enables.
REQ-011 d_addr_in  input  32  data byte address.
REQ-012 d_wdata_in  input  32  store data.
REQ-013 d_ack_out  output  1  one-cycle data completion pulse.
REQ-014 d_rdata_out  output  32  load data; valid while d_ack_out is high, held afterwards.
REQ-015 mem_en_out  output  1  one-cycle access strobe to the single-port memory.
REQ-016 mem_we_out, mem_be_out, mem_addr_out, mem_wdata_out  output  1/4/32/32  access fields; valid while mem_en_out is high.
REQ-017 mem_rdata_in  input  32  memory read data.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one transaction is in flight at a time.
REQ-019 IDLE, no request pending: stay in IDLE.
REQ-020 IDLE, any request pending: latch the grantee and its fields, then go to ISSUE.
REQ-021 Arbitration when only one request is pending: grant that request.
REQ-022 Arbitration when both requests are pending: grant the requester not granted last (round-robin flag last_d), then update last_d.
REQ-023 ISSUE: assert mem_en_out for one cycle with the latched fields.
REQ-024 mem_we_out/mem_be_out = latched d_we_in/d_be_in for data grants; forced to 0/4'b0000 for fetch grants.
REQ-025 ISSUE exit: go to WAIT if MEM_LAT > 1, else go straight to DONE.
REQ-026 WAIT: down-counter loaded with MEM_LAT-2; go to DONE when it reaches 0, giving MEM_LAT-1 WAIT cycles.
REQ-027 Read-data capture: mem_rdata_in is sampled on the edge closing the cycle MEM_LAT cycles after ISSUE, into the grantee's rdata register.
REQ-028 Stores complete with identical timing; d_rdata_out is unchanged by a store.
REQ-029 DONE: pulse the grantee's ack for one cycle; the other ack stays 0; return to IDLE.
REQ-030 Latency: request first seen in IDLE at cycle t gives mem_en_out at t+1 and ack at t+MEM_LAT+1.
REQ-031 A requester deasserts req, or presents a new request, in the cycle after its ack; a req high in the IDLE cycle after ack is a new request.
REQ-032 Requests arriving in ISSUE/WAIT/DONE are not sampled until the next IDLE; the in-flight transaction is never preempted.
REQ-033 mem_addr_out passes the full 32-bit address unmodified; alignment is the requester's responsibility.
REQ-034 i_ack_out and d_ack_out are never high in the same cycle.

Reset
REQ-035 While rst_in is high, the block is forced asynchronously to: state IDLE, mem_en_out=0, i_ack_out=0, d_ack_out=0, last_d=1 (fetch wins the first tie), WAIT counter=0.
REQ-036 While rst_in is high, mem_we_out/mem_be_out/mem_addr_out/mem_wdata_out=0 and i_rdata_out/d_rdata_out=0.
REQ-037 Reset mid-transaction: the transaction is abandoned, no ack is issued, and read data still returning from memory is discarded.
REQ-038 First request is sampled on the first rising edge after rst_in deasserts.

Verification
REQ-039 MEM_LAT=1, fetch only: i_req=1, i_addr=0x10, mem returns 0x00500093 -> mem_en at t+1 with addr 0x10, we=0, be=0; i_ack at t+2 with i_rdata=0x00500093.
REQ-040 MEM_LAT=3, store only: d_addr=0x100, be=4'b0011, wdata=0xA5A5A5A5 -> one mem_en cycle with we=1, be=0x3; d_ack at t+4; d_rdata unchanged.
REQ-041 Simultaneous fetch and load, held continuously from reset, MEM_LAT=1 -> grants alternate I, D, I, D; the acks never overlap and each request is acked once.
REQ-042 Load from 0x200 returning 0xDEADBEEF while a fetch is pending -> d_rdata=0xDEADBEEF; i_rdata retains its previous value; the fetch is issued in the next IDLE.
REQ-043 rst_in pulsed during WAIT (MEM_LAT=4) -> immediate IDLE; no ack ever appears for the aborted transaction; the next request completes normally.
REQ-044 Request held through its ack cycle and dropped the following cycle -> exactly one mem_en and one ack; no duplicate access.
